// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
// Requests are accepted on IMemReq & IMemReady; responses return in order on IMemRvalid.
interface fetch_unit_if;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic        IMemRvalid;
  logic [31:0] IMemRdata;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemReady,
    input  IMemRvalid,
    input  IMemRdata
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemReady,
    output IMemRvalid,
    output IMemRdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, feeding the IF/DE pipeline register,
// with branch redirect, load-use replay and squash support.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                IFFlush,
  input  logic                IFFlushBack,
  input  logic                BranchTaken,
  input  logic [31:0]         BranchTarget,
  fetch_unit_if.master        imem,
  output logic                IFDEValid,
  output logic [31:0]         IFDEInstr,
  output logic [31:0]         IFDEPC
);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pending_q, pending_d;
  logic        kill_q, kill_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  logic req, accept, resp;

  // A response arriving this cycle frees the single outstanding slot for a new request.
  assign req    = (state_q == StRun) & ~rst & ~BranchTaken & ~IFFlushBack &
                  (~pending_q | imem.IMemRvalid);
  assign accept = req & imem.IMemReady;
  assign resp   = imem.IMemRvalid & pending_q;

  assign imem.IMemReq  = req;
  assign imem.IMemAddr = fetch_pc_q;
  assign IFDEValid     = valid_q;
  assign IFDEInstr     = instr_q;
  assign IFDEPC        = pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pending_d  = pending_q;
    kill_d     = kill_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;

    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StBoot;
    endcase

    if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      pend_pc_d  = fetch_pc_q;
      pending_d  = 1'b1;
      kill_d     = 1'b0;
    end else if (resp) begin
      pending_d  = 1'b0;
    end

    // Redirects never coincide with acceptance since they suppress the request.
    if (BranchTaken) begin
      fetch_pc_d = {BranchTarget[31:2], 2'b00};
      kill_d     = 1'b1;
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
    end else if (IFFlushBack) begin
      fetch_pc_d = pc_q;
      kill_d     = 1'b1;
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
    end else if (IFFlush) begin
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
    end else if (resp && !kill_q) begin
      valid_d    = 1'b1;
      instr_d    = imem.IMemRdata;
      pc_d       = pend_pc_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= StBoot;
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      pend_pc_q  <= 32'h0;
      pending_q  <= 1'b0;
      kill_q     <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pending_q  <= pending_d;
      kill_q     <= kill_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model of the fetch stage plus a memory model with
// variable latency; directed scenarios first, then randomized traffic.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK;
  logic        rst, IFFlush, IFFlushBack, BranchTaken;
  logic [31:0] BranchTarget;
  logic        IFDEValid;
  logic [31:0] IFDEInstr, IFDEPC;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .CLK         (CLK),
    .rst         (rst),
    .IFFlush     (IFFlush),
    .IFFlushBack (IFFlushBack),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .imem        (bus),
    .IFDEValid   (IFDEValid),
    .IFDEInstr   (IFDEInstr),
    .IFDEPC      (IFDEPC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Reference model: outstanding requests as a queue of {pc, dead}.
  typedef struct {logic [31:0] pc; bit dead;} out_t;
  typedef struct {logic [31:0] addr; int cnt;} mem_t;

  bit          m_boot;
  logic [31:0] m_pc;
  out_t        m_out[$];
  bit          m_v;
  logic [31:0] m_instr, m_ipc;
  bit          m_req;

  mem_t        mem_q[$];
  int          lat_fix;

  bit          cur_r, cur_bt, cur_fb, cur_fl, cur_rdy, cur_rv;
  logic [31:0] cur_tgt, cur_rd;

  task automatic model_reset();
    m_boot  = 1;
    m_pc    = 32'h0;
    m_out.delete();
    m_v     = 0;
    m_instr = NOP;
    m_ipc   = 32'h0;
  endtask

  // Drive one cycle's inputs, let combinational outputs settle, and compare against the model.
  task automatic apply(input bit r, input bit bt, input bit fb, input bit fl,
                       input logic [31:0] tgt, input bit rdy, input bit spur);
    cur_r = r; cur_bt = bt; cur_fb = fb; cur_fl = fl; cur_tgt = tgt; cur_rdy = rdy;
    cur_rv = 0;
    cur_rd = $urandom;
    if (mem_q.size() > 0 && mem_q[0].cnt == 0) begin
      cur_rv = 1;
      cur_rd = data_of(mem_q[0].addr);
    end else if (mem_q.size() == 0 && spur) begin
      cur_rv = 1;
    end
    rst = r; BranchTaken = bt; IFFlushBack = fb; IFFlush = fl; BranchTarget = tgt;
    bus.IMemReady = rdy; bus.IMemRvalid = cur_rv; bus.IMemRdata = cur_rd;
    m_req = !r && !m_boot && !bt && !fb && (m_out.size() == 0 || cur_rv);
    #1;
    chk("req", 32'(bus.IMemReq), 32'(m_req));
    chk("addr", bus.IMemAddr, m_pc);
    chk("valid", 32'(IFDEValid), 32'(m_v));
    chk("instr", IFDEInstr, m_instr);
    chk("pc", IFDEPC, m_ipc);
  endtask

  // Advance model and memory across the rising edge, then wait for the next falling edge.
  task automatic finish_cycle();
    out_t        e;
    bit          got, acc;
    logic [31:0] old_pc;
    int          lat;
    acc    = m_req && cur_rdy;
    old_pc = m_pc;
    got    = 0;
    if (cur_r) begin
      model_reset();
      mem_q.delete();
    end else begin
      if (cur_rv && m_out.size() > 0) begin
        e   = m_out.pop_front();
        got = 1;
      end
      if (cur_bt || cur_fb) begin
        m_pc = cur_bt ? {cur_tgt[31:2], 2'b00} : m_ipc;
        foreach (m_out[i]) m_out[i].dead = 1;
        m_v     = 0;
        m_instr = NOP;
      end else if (cur_fl) begin
        m_v     = 0;
        m_instr = NOP;
      end else if (got && !e.dead) begin
        m_v     = 1;
        m_instr = cur_rd;
        m_ipc   = e.pc;
      end
      if (acc) begin
        m_out.push_back('{pc: old_pc, dead: 0});
        m_pc = old_pc + 32'd4;
      end
      m_boot = 0;
      if (cur_rv && mem_q.size() > 0 && mem_q[0].cnt == 0) mem_q.delete(0);
      foreach (mem_q[i]) if (mem_q[i].cnt > 0) mem_q[i].cnt--;
      if (acc) begin
        lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3));
        mem_q.push_back('{addr: old_pc, cnt: lat - 1});
      end
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 32'h0, 1, 0);
    finish_cycle();
  endtask

  // Runs idle cycles until IF/DE holds a valid instruction at pc; bounded.
  task automatic wait_ifde(input logic [31:0] pc, input string name);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (IFDEValid && IFDEPC == pc) begin
        ok = 1;
        break;
      end
      idle();
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  initial begin
    int cyc;
    rst = 1; IFFlush = 0; IFFlushBack = 0; BranchTaken = 0; BranchTarget = 0;
    bus.IMemReady = 0; bus.IMemRvalid = 0; bus.IMemRdata = 0;
    lat_fix = 1;
    @(negedge CLK);
    model_reset();
    mem_q.delete();

    // Reset values and boot sequence.
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 0, 0, 32'h0, 1, 1);
      chk("rst_req", 32'(bus.IMemReq), 32'd0);
      chk("rst_valid", 32'(IFDEValid), 32'd0);
      chk("rst_instr", IFDEInstr, NOP);
      chk("rst_pc", IFDEPC, 32'h0);
      finish_cycle();
    end
    apply(0, 0, 0, 0, 32'h0, 1, 0);
    chk("boot_req", 32'(bus.IMemReq), 32'd0);
    finish_cycle();
    apply(0, 0, 0, 0, 32'h0, 1, 0);
    chk("seq_addr0", bus.IMemAddr, 32'h0);
    chk("seq_req0", 32'(bus.IMemReq), 32'd1);
    finish_cycle();
    apply(0, 0, 0, 0, 32'h0, 1, 0);
    chk("seq_addr4", bus.IMemAddr, 32'h4);
    finish_cycle();
    apply(0, 0, 0, 0, 32'h0, 1, 0);
    chk("seq_addr8", bus.IMemAddr, 32'h8);
    chk("seq_pc0", IFDEPC, 32'h0);
    chk("seq_v0", 32'(IFDEValid), 32'd1);
    chk("seq_i0", IFDEInstr, 32'hC0DE_0000);
    finish_cycle();
    apply(0, 0, 0, 0, 32'h0, 1, 0);
    chk("seq_pc4", IFDEPC, 32'h4);
    finish_cycle();
    apply(0, 0, 0, 0, 32'h0, 1, 0);
    chk("seq_pc8", IFDEPC, 32'h8);
    finish_cycle();

    // Branch with a response still outstanding: the stale data is dropped.
    lat_fix = 3;
    idle();
    apply(0, 1, 0, 0, 32'h0000_1003, 1, 0);
    chk("br_req", 32'(bus.IMemReq), 32'd0);
    finish_cycle();
    apply(0, 0, 0, 0, 32'h0, 1, 0);
    chk("br_addr", bus.IMemAddr, 32'h0000_1000);
    chk("br_valid", 32'(IFDEValid), 32'd0);
    finish_cycle();
    cyc = 0;
    while (cyc < 10) begin
      apply(0, 0, 0, 0, 32'h0, 1, 0);
      if (bus.IMemReq) break;
      finish_cycle();
      cyc++;
    end
    chk("br_reissue", bus.IMemAddr, 32'h0000_1000);
    finish_cycle();
    apply(0, 0, 0, 0, 32'h0, 1, 0);
    chk("br_dropped", 32'(IFDEValid), 32'd0);
    finish_cycle();

    // Load-use replay of the instruction at 0x40.
    lat_fix = 1;
    apply(0, 1, 0, 0, 32'h0000_0040, 1, 0);
    finish_cycle();
    wait_ifde(32'h40, "fb_reach40");
    apply(0, 0, 1, 0, 32'h0, 1, 0);
    finish_cycle();
    apply(0, 0, 0, 0, 32'h0, 1, 0);
    chk("fb_valid", 32'(IFDEValid), 32'd0);
    chk("fb_addr", bus.IMemAddr, 32'h40);
    chk("fb_req", 32'(bus.IMemReq), 32'd1);
    finish_cycle();
    wait_ifde(32'h40, "fb_replay40");
    chk("fb_instr", IFDEInstr, 32'hC0DE_0040);

    // Branch beats replay in the same cycle.
    apply(0, 1, 1, 0, 32'h0000_0200, 1, 0);
    finish_cycle();
    apply(0, 0, 0, 0, 32'h0, 1, 0);
    chk("prio_addr", bus.IMemAddr, 32'h200);
    finish_cycle();
    wait_ifde(32'h200, "prio_pc200");

    // Stall at the top of the address space, stray response, then wrap.
    apply(0, 1, 0, 0, 32'hFFFF_FFFF, 1, 0);
    finish_cycle();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 32'h0, 0, (i == 1));
      chk("wrap_hold", bus.IMemAddr, 32'hFFFF_FFFC);
      chk("wrap_req", 32'(bus.IMemReq), 32'd1);
      finish_cycle();
    end
    idle();
    apply(0, 0, 0, 0, 32'h0, 1, 0);
    chk("wrap_zero", bus.IMemAddr, 32'h0);
    chk("stray_ignored", 32'(IFDEValid), 32'd0);
    finish_cycle();
    wait_ifde(32'hFFFF_FFFC, "wrap_capture");

    // Randomized traffic.
    lat_fix = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 9) == 0), tgt,
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 7) == 0));
      finish_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
